// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency imem
// reads and queues returned instructions with their PCs for decode.
module fetch_unit #(
  parameter int                 XLEN     = 32,
  parameter int                 ILEN     = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic [ILEN-1:0]            imem_instr_i,
  output logic [ILEN-1:0]            instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  fetch_pc_p0;
  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [ILEN-1:0]  q_instr [DEPTH];
  logic [XLEN-1:0]  q_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credits_used;
  logic             issue, push, pop;

  // Credits count the in-flight request so a full queue can never be overrun.
  assign credits_used = {1'b0, count} + (CNT_W+1)'(vld_p1);
  assign issue        = start_i & ~redirect_i & ~rst_i & (credits_used < (CNT_W+1)'(DEPTH));
  assign push         = vld_p1 & ~redirect_i & ~rst_i;
  assign valid_o      = (count != '0) & ~redirect_i & ~rst_i;
  assign pop          = valid_o & ready_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_p0;
  assign instr_o     = valid_o ? q_instr[rd_ptr] : '0;
  assign pc_o        = valid_o ? q_pc[rd_ptr]    : '0;
  assign count_o     = count;

  // Stage p0 -> p1: fetch PC and the request in flight to imem
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_p0 <= redirect_pc_i & ~XLEN'(3);
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) fetch_pc_p0 <= fetch_pc_p0 + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) pc_p1 <= fetch_pc_p0;
  end

  // Stage p1 -> queue: response capture and head consumption
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_instr_i;
      q_pc[wr_ptr]    <= pc_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && !pop && count == CNT_W'(DEPTH)));
      assert (count <= CNT_W'(DEPTH));
      assert (!valid_o || pc_o[1:0] == 2'b00);
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the bare PC, PC+4 adder and direct instruction-memory hookup of the single-cycle core. It owns the fetch PC and issues requests to a synchronous instruction memory with one-cycle read latency. Returned instructions are buffered with their PCs in a DEPTH-entry queue and handed to decode over a valid/ready handshake; stall and branch/jump redirect with squash are supported.

Parameters:
XLEN, 32, PC/address width in bits
ILEN, 32, instruction width in bits
DEPTH, 4, instruction queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  fetch enable; no new requests while low
redirect_i  in  1  branch/jump taken; flush and refetch from redirect_pc_i
redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
imem_req_o  out  1  request valid this cycle
imem_addr_o  out  XLEN  request address (current fetch PC)
imem_instr_i  in  ILEN  data for the request issued in the previous cycle
instr_o  out  ILEN  queue-head instruction; 0 when valid_o=0
pc_o  out  XLEN  PC of the queue-head instruction; 0 when valid_o=0
valid_o  out  1  queue head valid
ready_i  in  1  decode accepts the head; pop occurs on valid_o & ready_i
count_o  out  $clog2(DEPTH+1)  queued entries

Behaviour:
- Reset (rst_i=1 at a clock edge): fetch_pc<=RESET_PC, count<=0, inflight<=0, rd/wr pointers<=0. While rst_i=1, imem_req_o=0 and valid_o=0. Queue storage is not reset. Reset wins over every other input, including mid-operation with requests in flight; a response due the cycle after reset is dropped.
- Issue: imem_req_o = start_i & ~redirect_i & ~rst_i & (count + inflight < DEPTH). This is a credit check: it ignores a same-cycle pop, so overflow is impossible. imem_addr_o = fetch_pc at all times.
- On issue: fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN), inflight <= 1, inflight_pc <= fetch_pc. With no issue: inflight <= 0.
- Response: when inflight=1, imem_instr_i is valid this cycle. It is pushed together with inflight_pc unless redirect_i=1 (squash).
- Pop: valid_o & ready_i advances rd pointer. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- valid_o = (count != 0) & ~redirect_i & ~rst_i. instr_o and pc_o are combinational from the queue head.
- Redirect (redirect_i=1), highest priority after reset:
  - no issue this cycle
  - no pop; the head is not consumed even if ready_i=1
  - the arriving response is discarded
  - next cycle: count=0, pointers=0, inflight=0, fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00}
  - back-to-back redirects: the last one wins
- start_i=0: the in-flight response is still pushed and the queue drains normally. fetch_pc holds.
- Latency: a request in cycle N is pushed at the end of N+1; valid_o is first seen in N+2. With ready_i=1 continuously, throughput is 1 instruction/cycle in steady state.
- Full: count==DEPTH gives imem_req_o=0 until a pop frees a credit; the PC sequence continues with no gap or duplicate.
- Assertions: no push when count==DEPTH; count <= DEPTH; pc_o[1:0]==0 whenever valid_o=1.

Test Plan:
- Reset then start: RESET_PC=0, start_i=1, ready_i=1, memory word at addr A = A|1 -> requests 0,4,8,...; first valid_o two cycles after first req; pc_o=0,4,8 on consecutive cycles; instr_o=pc_o|1.
- Backpressure: ready_i=0 for 10 cycles, DEPTH=4 -> count_o saturates at 4, imem_req_o=0; raise ready_i -> pops 0,4,8,12,16 with no skipped or duplicated PC.
- Redirect with one request in flight: redirect_i=1 with redirect_pc_i=0x103 while the queue holds 2 entries -> queue flushed, in-flight response dropped, next imem_addr_o=0x100, next pc_o=0x100.
- Back-to-back redirects to 0x40 then 0x80 -> only 0x80 stream appears; nothing from 0x40 reaches valid_o.
- start_i drop: lower start_i in the same cycle as a request -> that response is still delivered, no further requests, queue drains, fetch_pc holds and resumes on start_i=1.
- Wrap and reset mid-run: RESET_PC=0xFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst_i with 3 entries queued -> next cycle count_o=0, valid_o=0, imem_addr_o=RESET_PC.
